// File: rtl/uart_pkg.sv
// Shared types and encodings for the UART receive path.
// UART_RX_BREAK_EN adds the BREAK_WAIT state to state_t.
package uart_pkg;

`ifdef UART_RX_BREAK_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK_WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
    } state_t;
`endif

    localparam logic [1:0] PAR_SPACE = 2'b00;
    localparam logic [1:0] PAR_MARK  = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_ODD   = 2'b11;

    localparam logic [1:0] DSZ_5 = 2'b00;
    localparam logic [1:0] DSZ_6 = 2'b01;
    localparam logic [1:0] DSZ_7 = 2'b10;
    localparam logic [1:0] DSZ_8 = 2'b11;

    function automatic logic [3:0] data_bits(input logic [1:0] ds);
        logic [3:0] n;
        n = 4'd8;
        case (ds)
            DSZ_5: n = 4'd5;
            DSZ_6: n = 4'd6;
            DSZ_7: n = 4'd7;
            DSZ_8: n = 4'd8;
        endcase
        return n;
    endfunction

    // Expected parity bit for an LSB-aligned word whose unused MSBs are zero.
    function automatic logic parity_expected(input logic [1:0] mode, input logic [7:0] w);
        logic p;
        p = 1'b0;
        case (mode)
            PAR_ODD:   p = ~(^w);
            PAR_EVEN:  p = ^w;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every div_i+1 clocks, restartable to realign phase.
module uart_baud_tick #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (restart_i || cnt_q == '0) begin
            cnt_q <= div_i;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick_o = (cnt_q == '0) && !restart_i;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-of-3 majority per bit, parity/framing/overrun flags, ready/valid output.
// Define UART_RX_BREAK_EN to add break detection (break_det port and BREAK_WAIT state).
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [1:0]           data_size,
    input  logic                 parity_en,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bit_size,
    input  logic                 rx,
    output logic [7:0]           data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
`ifdef UART_RX_BREAK_EN
    output logic                 break_det,
`endif
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_S0  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_MAJ = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);

    logic                 sync1_q, rxs_q, rxs_prev_q;
    state_t               state_q;
    logic [TW-1:0]        tcnt_q;
    logic [3:0]           bitcnt_q;
    logic                 stop_idx_q;
    logic                 perr_q, ferr_q;
    logic [7:0]           data_q;
    logic                 valid_q, parity_err_q, frame_err_q, overrun_q, busy_q;

    // Frame datapath and configuration captured at the start edge (no reset needed)
    logic [7:0]           shreg_q;
    logic                 s0_q, s1_q;
    logic [3:0]           nbits_q;
    logic                 par_en_q, stop_two_q;
    logic [1:0]           par_mode_q;
    logic [DIV_WIDTH-1:0] div_q;

    logic                 tick, start_d, maj_d, maj_tick_d, end_tick_d;
    logic [DIV_WIDTH-1:0] div_d;
    logic [7:0]           word_d;

    assign start_d    = (state_q == ST_IDLE) && rxs_prev_q && !rxs_q;
    assign maj_d      = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign maj_tick_d = tick && (tcnt_q == T_MAJ);
    assign end_tick_d = tick && (tcnt_q == T_END);
    assign div_d      = (state_q == ST_IDLE) ? baud_div : div_q;
    assign word_d     = shreg_q >> (4'd8 - nbits_q);

    uart_baud_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .restart_i (start_d),
        .div_i     (div_d),
        .tick_o    (tick)
    );

`ifdef UART_RX_BREAK_EN
    logic zero_q, break_q, brk_d;
    assign brk_d     = zero_q & ~maj_d;
    assign break_det = break_q;
`endif

    always_ff @(posedge clk) begin
        if (start_d) begin
            nbits_q    <= data_bits(data_size);
            par_en_q   <= parity_en;
            par_mode_q <= parity_mode;
            stop_two_q <= stop_bit_size;
            div_q      <= baud_div;
        end
        if (tick && tcnt_q == T_S0) s0_q <= rxs_q;
        if (tick && tcnt_q == T_S1) s1_q <= rxs_q;
        if (state_q == ST_DATA && maj_tick_d) shreg_q <= {maj_d, shreg_q[7:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            rxs_q        <= 1'b1;
            rxs_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            tcnt_q       <= '0;
            bitcnt_q     <= '0;
            stop_idx_q   <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef UART_RX_BREAK_EN
            zero_q       <= 1'b1;
            break_q      <= 1'b0;
`endif
        end else begin
            sync1_q    <= rx;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
            if (valid_q && ready) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
            if (tick) tcnt_q <= (tcnt_q == T_END) ? '0 : tcnt_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q    <= ST_START;
                        busy_q     <= 1'b1;
                        tcnt_q     <= '0;
                        bitcnt_q   <= '0;
                        stop_idx_q <= 1'b0;
                        perr_q     <= 1'b0;
                        ferr_q     <= 1'b0;
`ifdef UART_RX_BREAK_EN
                        zero_q     <= 1'b1;
`endif
                    end
                end
                ST_START: begin
                    if (maj_tick_d && maj_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (end_tick_d) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (maj_tick_d) begin
                        bitcnt_q <= bitcnt_q + 1'b1;
`ifdef UART_RX_BREAK_EN
                        zero_q   <= zero_q & ~maj_d;
`endif
                    end
                    if (end_tick_d && bitcnt_q == nbits_q) begin
                        state_q <= par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (maj_tick_d) begin
                        perr_q <= maj_d != parity_expected(par_mode_q, word_d);
`ifdef UART_RX_BREAK_EN
                        zero_q <= zero_q & ~maj_d;
`endif
                    end
                    if (end_tick_d) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (maj_tick_d && stop_idx_q == stop_two_q) begin
                        // Frame completes at the last stop bit's majority point
`ifdef UART_RX_BREAK_EN
                        state_q <= brk_d ? ST_BREAK_WAIT : ST_IDLE;
                        busy_q  <= brk_d;
                        tcnt_q  <= '0;
`else
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
`endif
                        if (!valid_q || ready) begin
                            valid_q      <= 1'b1;
                            data_q       <= word_d;
                            parity_err_q <= perr_q;
                            frame_err_q  <= ferr_q | ~maj_d;
`ifdef UART_RX_BREAK_EN
                            break_q      <= brk_d;
`endif
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else if (maj_tick_d) begin
                        ferr_q <= ferr_q | ~maj_d;
`ifdef UART_RX_BREAK_EN
                        zero_q <= zero_q & ~maj_d;
`endif
                    end else if (end_tick_d) begin
                        stop_idx_q <= 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_EN
                ST_BREAK_WAIT: begin
                    if (!rxs_q) begin
                        tcnt_q <= '0;
                    end else if (end_tick_d) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: next generation of the team's UART receive path. Runs entirely on the system clock with a tick-enable baud generator (no derived clocks). Majority-votes each bit, reports parity/framing/overrun errors, and delivers bytes over a ready/valid handshake. Sits between the `rx` pin and the register/FIFO layer of the UART subsystem.

## Interface
- `DIV_WIDTH`, 16: width of the runtime baud divisor.
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-low reset.
- `baud_div`  in  DIV_WIDTH  oversample tick period minus 1, in `clk` cycles.
- `data_size`  in  2  00: 5 bit; 01: 6; 10: 7; 11: 8.
- `parity_en`  in  1  parity bit present.
- `parity_mode`  in  2  11: odd; 10: even; 01: mark (1); 00: space (0).
- `stop_bit_size`  in  1  0: 1 stop bit; 1: 2 stop bits.
- `rx`  in  1  asynchronous serial input; idle high.
- `data`  out  8  received word, LSB-aligned, unused MSBs 0.
- `valid`  out  1  `data` and error flags are held stable.
- `ready`  in  1  consumer accepts on `valid & ready`.
- `parity_err`  out  1  parity mismatch for the presented word.
- `frame_err`  out  1  any stop bit sampled 0 for the presented word.
- `overrun`  out  1  sticky: a frame completed while `valid & ~ready`.
- `busy`  out  1  high in every state except IDLE.
- `break_det`  out  1  break flag (present only under `UART_RX_BREAK_EN`).

## Operation
- `rx` passes through a 2-flop synchroniser; all logic uses the synchronised value `rxs`.
- Tick: counter reloads `baud_div`, pulses when it reaches 0; `baud_div=0` means a tick every cycle. Counter is restarted on start-edge detection, aligning bit phase.
- Config inputs are latched on start-edge detection; changes mid-frame have no effect.
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE: falling edge of `rxs` → START, tick-in-bit counter cleared.
  - Each bit lasts OVERSAMPLE ticks. Samples taken at ticks OVERSAMPLE/2−1, /2, /2+1; bit value = 2-of-3 majority, resolved at tick /2+1.
  - START: majority 1 → false start, back to IDLE with no output. Otherwise → DATA at end of bit.
  - DATA: LSB first, shifts 5–8 bits per `data_size`, then → PARITY if `parity_en`, else STOP.
  - PARITY: expected = `parity_mode[0]` XOR (`parity_mode[1]` & XOR of data bits); mismatch sets `parity_err`.
  - STOP: 1 or 2 bits; any 0 sample sets `frame_err`. Frame completes at the majority point of the last stop bit (not end of bit), → IDLE.
- On completion with output slot empty: load `data`/`parity_err`/`frame_err`, assert `valid`.
- On completion while `valid & ~ready`: new frame dropped, old word kept, `overrun` set. A completion in the same cycle as an accept handshake is loaded normally (no overrun).
- `overrun` clears on the next accepted handshake.
- After a `frame_err` frame, IDLE requires a fresh falling edge; a held-low line does not restart reception.

## Timing
- Reset (`rst`=0 at a `clk` edge): state IDLE; `data`=0, `valid`=0, all error flags 0, `busy`=0, synchroniser flops 1. Reset mid-frame abandons the frame with no output.
- Edge to START: 2 cycles synchroniser + 1 cycle detect.
- `valid` rises 1 cycle after the last stop-bit majority tick; it is held until `ready`. It falls the cycle after `valid & ready`.
- `busy` rises with START entry and falls with the `valid` load cycle.

## Configuration
- `UART_RX_BREAK_EN` defined: a frame with all data bits, parity (if enabled) and stop bits sampled 0 sets `break_det` alongside `frame_err`, `data`=0. `break_det` shares the `valid` handshake. The receiver enters BREAK_WAIT and stays there until `rxs`=1 for one full bit time, then goes to IDLE.
- Not defined: no `break_det` port and no BREAK_WAIT state; a break is reported as `frame_err` with `data`=0.

## Structure
- `uart_pkg`: `state_t` enum, parity-mode and data-size encodings, helper function for bit count from `data_size`.
- Sub-module `uart_baud_tick` (`DIV_WIDTH`): divisor counter, sync restart input, `tick` output. Reusable by the future matching transmitter.

## Test plan
- `baud_div`=3, 8N1, send 0xA5 with `ready`=1 → `valid` for 1 cycle, `data`=0xA5, no errors.
- 7E2, send 0x5A with wrong parity bit → `data`=0x5A, `parity_err`=1, `frame_err`=0.
- `ready`=0, send 0x11 then 0x22 → `data` stays 0x11, `overrun`=1. Then `ready`=1 → accepted, `overrun`=0.
- 2-tick low glitch on `rx` in IDLE → false start, no `valid`, `busy` returns 0. Single-tick inverted glitch at a data-bit centre → majority still correct byte.
- 8N1 stop bit 0 with data 0x3C → `frame_err`=1, `data`=0x3C. Reset asserted mid-DATA → all outputs 0, next frame 0x81 received correctly.
- `UART_RX_BREAK_EN`: `rx` low for 20 bit times → one `valid` with `break_det`=1, `frame_err`=1, `data`=0, no further frames until `rx` high for 1 bit.
